// File: rtl/quant_writeback_ctrl.sv
// quant_writeback_ctrl
//
// Accepts signed accumulator rows, clips every lane to the signed
// OUTPUT_DATA_WIDTH range, and writes each quantized row to SRAM as
// WORDS_PER_ROW consecutive words, starting at a job base address.
//
// State table
//   state     | meaning
//   ----------+-------------------------------------------------------
//   S_IDLE    | waiting for start; outputs quiet, sat_count held
//   S_CAPTURE | acc_ready high, waiting for an accumulator row
//   S_WRITE   | one SRAM word per cycle from the row buffer
//   S_DONE    | one-cycle done pulse, then back to S_IDLE
//
// Ports
//   clk, srstn           clock, synchronous active-low reset
//   start                begin a job (sampled only in S_IDLE)
//   base_addr, num_rows  job parameters, latched on start
//   acc_valid/acc_ready  row handshake, acc_data carries the row
//   sram_we/addr/wdata   SRAM write port
//   busy, done           job status
//   sat_count            lanes clipped in the current/last job
module quant_writeback_ctrl #(
    parameter int ARRAY_SIZE        = 16,
    parameter int DATA_WIDTH        = 8,
    parameter int OUTPUT_DATA_WIDTH = 16,
    parameter int SRAM_DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH        = 10
) (
    input  logic                                     clk,
    input  logic                                     srstn,
    input  logic                                     start,
    input  logic [ADDR_WIDTH-1:0]                    base_addr,
    input  logic [7:0]                               num_rows,
    input  logic                                     acc_valid,
    input  logic [ARRAY_SIZE*(2*DATA_WIDTH+5)-1:0]   acc_data,
    output logic                                     acc_ready,
    output logic                                     sram_we,
    output logic [ADDR_WIDTH-1:0]                    sram_addr,
    output logic [SRAM_DATA_WIDTH-1:0]               sram_wdata,
    output logic                                     busy,
    output logic                                     done,
    output logic [15:0]                              sat_count
);

    localparam int ACC_W         = 2*DATA_WIDTH + 5;
    localparam int ROW_W         = ARRAY_SIZE*OUTPUT_DATA_WIDTH;
    localparam int WORDS_PER_ROW = ROW_W/SRAM_DATA_WIDTH;
    localparam int WIDX_W        = (WORDS_PER_ROW > 1) ? $clog2(WORDS_PER_ROW) : 1;
    localparam int CNT_W         = $clog2(ARRAY_SIZE + 1);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_CAPTURE = 2'd1;
    localparam logic [1:0] S_WRITE   = 2'd2;
    localparam logic [1:0] S_DONE    = 2'd3;

    // QMIN is the two's complement of QMAX+1, i.e. its bitwise inverse.
    localparam logic signed [ACC_W-1:0] QMAX = ACC_W'((1 << (OUTPUT_DATA_WIDTH-1)) - 1);
    localparam logic signed [ACC_W-1:0] QMIN = ~QMAX;

    logic [1:0]               state;
    logic [ADDR_WIDTH-1:0]    addr_ptr;
    logic [7:0]               rows_total;
    logic [7:0]               rows_done;
    logic [WIDX_W-1:0]        word_idx;
    logic [ROW_W-1:0]         row_buf;

    logic [ROW_W-1:0]         quant_row;
    logic [CNT_W-1:0]         sat_lanes;
    logic signed [ACC_W-1:0]  lane;
    logic [16:0]              sat_sum;
    logic [15:0]              sat_next;
    logic                     last_word;

    // Clip each lane; only strictly out-of-range lanes count as saturated,
    // so a lane already sitting at QMAX/QMIN passes through uncounted.
    always_comb begin
        quant_row = '0;
        sat_lanes = '0;
        lane      = '0;
        for (int i = 0; i < ARRAY_SIZE; i++) begin
            lane = $signed(acc_data[i*ACC_W +: ACC_W]);
            if (lane > QMAX) begin
                quant_row[i*OUTPUT_DATA_WIDTH +: OUTPUT_DATA_WIDTH] = QMAX[OUTPUT_DATA_WIDTH-1:0];
                sat_lanes = sat_lanes + CNT_W'(1);
            end else if (lane < QMIN) begin
                quant_row[i*OUTPUT_DATA_WIDTH +: OUTPUT_DATA_WIDTH] = QMIN[OUTPUT_DATA_WIDTH-1:0];
                sat_lanes = sat_lanes + CNT_W'(1);
            end else begin
                quant_row[i*OUTPUT_DATA_WIDTH +: OUTPUT_DATA_WIDTH] = lane[OUTPUT_DATA_WIDTH-1:0];
            end
        end
    end

    assign sat_sum   = {1'b0, sat_count} + 17'(sat_lanes);
    assign sat_next  = sat_sum[16] ? 16'hFFFF : sat_sum[15:0];
    assign last_word = (word_idx == WIDX_W'(WORDS_PER_ROW - 1));

    always_ff @(posedge clk) begin
        if (!srstn) begin
            state      <= S_IDLE;
            addr_ptr   <= '0;
            rows_total <= '0;
            rows_done  <= '0;
            word_idx   <= '0;
            row_buf    <= '0;
            sat_count  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        addr_ptr   <= base_addr;
                        rows_total <= num_rows;
                        rows_done  <= '0;
                        sat_count  <= '0;
                        state      <= (num_rows == 8'd0) ? S_DONE : S_CAPTURE;
                    end
                end
                S_CAPTURE: begin
                    if (acc_valid) begin
                        row_buf   <= quant_row;
                        word_idx  <= '0;
                        sat_count <= sat_next;
                        state     <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    addr_ptr <= addr_ptr + ADDR_WIDTH'(1);
                    word_idx <= word_idx + WIDX_W'(1);
                    if (last_word) begin
                        rows_done <= rows_done + 8'd1;
                        state     <= (rows_done + 8'd1 == rows_total) ? S_DONE : S_CAPTURE;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // All outputs decode registered state only.
    assign acc_ready = (state == S_CAPTURE);
    assign sram_we   = (state == S_WRITE);
    assign busy      = (state != S_IDLE);
    assign done      = (state == S_DONE);
    assign sram_addr = addr_ptr;

    always_comb begin
        sram_wdata = '0;
        for (int k = 0; k < WORDS_PER_ROW; k++) begin
            if (word_idx == WIDX_W'(k)) begin
                sram_wdata = row_buf[k*SRAM_DATA_WIDTH +: SRAM_DATA_WIDTH];
            end
        end
    end

endmodule
